// File: rtl/vga_sync_stream.sv
// vga_sync_stream: VGA timing generator producing the registered coordinate/sync stream and a frame counter.
module vga_sync_stream #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        px_clk,
  input  logic        reset_n,
  input  logic        en,
  output logic [22:0] strVGA,
  output logic [7:0]  frame_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic [9:0]  hc_q, vc_q, hc_d, vc_d;
  logic [7:0]  frame_cnt_d;
  logic [22:0] str_d;
  logic        h_end, v_end, av, hs, vs;
  // Decode uses the current counters, so the registered stream lags them by one edge.
  always_comb begin
    h_end       = int'(hc_q) == H_TOTAL - 1;
    v_end       = int'(vc_q) == V_TOTAL - 1;
    hc_d        = h_end ? 10'd0 : hc_q + 10'd1;
    vc_d        = h_end ? (v_end ? 10'd0 : vc_q + 10'd1) : vc_q;
    frame_cnt_d = (h_end && v_end) ? frame_cnt + 8'd1 : frame_cnt;
    av          = (int'(hc_q) < H_ACTIVE) && (int'(vc_q) < V_ACTIVE);
    hs          = (int'(hc_q) >= H_ACTIVE + H_FP && int'(hc_q) < H_ACTIVE + H_FP + H_SYNC) ? HS_POL : ~HS_POL;
    vs          = (int'(vc_q) >= V_ACTIVE + V_FP && int'(vc_q) < V_ACTIVE + V_FP + V_SYNC) ? VS_POL : ~VS_POL;
    str_d       = {av, vs, hs, vc_q, hc_q};
  end
  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q      <= '0;
      vc_q      <= '0;
      frame_cnt <= '0;
      strVGA    <= {1'b0, ~VS_POL, ~HS_POL, 20'd0};
    end else if (en) begin
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      frame_cnt <= frame_cnt_d;
      strVGA    <= str_d;
    end
  end
endmodule
